lfsr_stream_decrypt: RTL and testbench
======================================

Name: lfsr_stream_decrypt

Overview:
Receive-side stream cipher. It regenerates the same 8-bit LFSR keystream as the transmit-side key generator and XORs it onto incoming ciphertext bytes to recover plaintext. It sits between the byte receiver (ciphertext source, valid/ready) and the plaintext consumer (valid/ready), with a 2-entry output buffer. Frame resync is by a start-of-frame flag that reseeds the keystream from the loaded key.

Parameters:
FIFO_DEPTH, 2, output buffer entries; fixed at 2, the count width is sized for it.
CNT_W, 16, width of the per-frame byte counter.

Ports:
clk  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset
key_work  in  8  key/seed value, sampled on load_key
load_key  in  1  single-cycle pulse; latch key_work and (re)seed the LFSR
in_valid  in  1  ciphertext byte valid
in_data  in  8  ciphertext byte
in_sof  in  1  qualifies in_data as the first byte of a frame
in_ready  out  1  block can accept a byte this cycle
out_valid  out  1  plaintext byte available
out_data  out  8  plaintext byte (FIFO head)
out_ready  in  1  consumer takes the FIFO head this cycle
keyed  out  1  a key has been loaded since reset
frame_cnt  out  CNT_W  bytes accepted in the current frame

Behaviour:
- Reset (clear=0, asynchronous):
  - State IDLE; key_reg=0, lfsr=8'h01.
  - FIFO empty; out_valid=0, out_data=0, keyed=0, frame_cnt=0, in_ready=0.
- LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - next(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
  - Keystream byte = current state; the LFSR advances once per accepted byte.
- Seed rule: a zero key is replaced by 8'h01 in both key_reg and lfsr, because an all-zero LFSR would lock up.
- FSM:
  - IDLE: in_ready=0.
  - IDLE -> RUN on load_key.
  - RUN stays in RUN; a later load_key re-keys in place. There is no return to IDLE except reset.
- Accept: accept = in_valid & in_ready, with in_ready = (state==RUN) & (fifo_count<2). in_ready is combinational from registered state only and never depends on out_ready.
- Keystream per accept: ks = in_sof ? key_reg : lfsr.
  - The pushed byte is in_data ^ ks.
  - lfsr <= next(ks).
  - frame_cnt <= in_sof ? 1 : frame_cnt+1, saturating at all-ones.
- Latency: a byte accepted at edge N is at the FIFO head with out_valid=1 after edge N (1 cycle) when the FIFO was empty. Otherwise bytes leave in order.
- Pop: a pop happens on out_valid & out_ready. out_data holds stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle:
  - At count 1: count stays 1 and the new byte becomes the head after the edge.
  - At count 2: no push is possible (in_ready=0); the pop only reduces count to 1.
- load_key in RUN:
  - key_reg and lfsr take the new seed; keyed=1; frame_cnt=0; FIFO contents are kept.
  - If an accept occurs in the same cycle, that byte uses the old ks, and the new seed overrides the LFSR advance.
  - frame_cnt=0 takes priority over the accept's increment.
- load_key in IDLE: same seeding, then transition to RUN; in_ready rises the next cycle.
- in_valid while not ready: ignored; no state change. The source must hold data, per standard valid/ready.
- Reset mid-frame: everything returns to reset values immediately; buffered bytes are discarded.

Test Plan:
1. Load key 8'hAA, then send 3 bytes 8'h00 (first with in_sof=1) and hold out_ready=1 -> out_data 8'hAA, 8'h55, 8'hAB; frame_cnt=3; LFSR ends at 8'h57.
2. Same key, in_sof=1 byte 8'hE2 -> out_data 8'h48. Then a second frame with in_sof=1 byte 8'hE2 -> again 8'h48, showing the resync; frame_cnt goes back to 1.
3. Hold out_ready=0 and offer 3 bytes -> 2 accepted, in_ready=0 with the 3rd held on the input. Raise out_ready -> 3 plaintext bytes out in order with no loss or duplicates.
4. Before any load_key, assert in_valid with data -> in_ready=0, out_valid=0, keyed=0. Then pulse load_key -> in_ready=1 the next cycle.
5. load_key with key_work=8'h00, then send 8'h00 with sof -> out_data 8'h01 (zero-seed substitution).
6. Pull clear low mid-frame with 2 bytes buffered -> out_valid=0, frame_cnt=0, keyed=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/lfsr_stream_decrypt.sv
// Receive-side LFSR stream cipher: XORs the regenerated keystream onto ciphertext
// bytes and buffers the plaintext in a 2-entry output FIFO.
module lfsr_stream_decrypt #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [7:0]       key_work,
  input  logic             load_key,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             keyed,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    key_reg, lfsr, ks, seed, plain, tail;
  logic [CW-1:0] fifo_count;
  logic          accept, pop;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: keying is the only way out of IDLE
  always_comb begin
    state_nxt = state;
    if (state == IDLE && load_key) state_nxt = RUN;
  end

  // Output decode from registered state and occupancy only
  always_comb begin
    in_ready = 1'b0;
    if (state == RUN && fifo_count < CW'(FIFO_DEPTH)) in_ready = 1'b1;
  end

  // A zero seed would lock the LFSR at zero, so it is replaced by 8'h01
  always_comb begin
    seed      = (key_work == 8'h00) ? 8'h01 : key_work;
    ks        = in_sof ? key_reg : lfsr;
    plain     = in_data ^ ks;
    accept    = in_valid & in_ready;
    out_valid = (fifo_count != '0);
    pop       = out_valid & out_ready;
  end

  // Key, keystream and frame counter; a reseed overrides the accept's advance
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      key_reg   <= 8'h00;
      lfsr      <= 8'h01;
      keyed     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (load_key) begin
        key_reg <= seed;
        lfsr    <= seed;
      end else if (accept) begin
        lfsr <= lfsr_next(ks);
      end
      if (load_key) keyed <= 1'b1;
      if (load_key) begin
        frame_cnt <= '0;
      end else if (accept) begin
        if (in_sof)                frame_cnt <= CNT_W'(1);
        else if (frame_cnt != '1)  frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  // Two-entry FIFO: out_data is the head register, tail holds the second entry
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      out_data   <= 8'h00;
      tail       <= 8'h00;
      fifo_count <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10: begin
          if (fifo_count == '0) out_data <= plain;
          else                  tail     <= plain;
          fifo_count <= fifo_count + CW'(1);
        end
        2'b01: begin
          out_data   <= tail;
          fifo_count <= fifo_count - CW'(1);
        end
        2'b11: out_data <= plain;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Directed bench for lfsr_stream_decrypt with hand-computed plaintext vectors.
module tb_lfsr_stream_decrypt;

  logic        clk = 1'b0;
  logic        clear;
  logic [7:0]  key_work;
  logic        load_key;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        keyed;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  lfsr_stream_decrypt #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .clear(clear), .key_work(key_work), .load_key(load_key),
    .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .keyed(keyed), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Record every byte that will be popped at the coming rising edge
  always @(negedge clk) begin
    if (clear && out_valid && out_ready) rx.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic load(input logic [7:0] k);
    key_work = k;
    load_key = 1'b1;
    step();
    load_key = 1'b0;
  endtask

  task automatic check_rx(input string tag);
    repeat (3) step();
    check({tag, "_count"}, 32'(rx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(exp_q[i]));
    rx.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; key_work = 8'h00; load_key = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_keyed",     32'(keyed),     32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    clear = 1'b1;
    step();

    // Test 4: data offered before any key is ignored
    in_valid = 1'b1; in_data = 8'h55;
    step(); step();
    check("idle_in_ready",  32'(in_ready),  32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_keyed",     32'(keyed),     32'd0);
    // Test 5 seed: zero key substitutes 8'h01; the held 8'h55 is taken next
    load(8'h00);
    check("load_in_ready", 32'(in_ready), 32'd1);
    check("load_keyed",    32'(keyed),    32'd1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    send(8'h00, 1'b1);
    exp_q = {8'h54, 8'h01};
    check_rx("zero_seed");

    // Re-key in RUN with a same-cycle accept: byte uses old ks (8'h02)
    in_valid = 1'b1; in_data = 8'h00; in_sof = 1'b0;
    key_work = 8'hAA; load_key = 1'b1;
    step();
    load_key = 1'b0; in_valid = 1'b0;
    check("rekey_frame_cnt", 32'(frame_cnt), 32'd0);
    send(8'h00, 1'b0);
    check("rekey_cnt_after", 32'(frame_cnt), 32'd1);
    exp_q = {8'h02, 8'hAA};
    check_rx("rekey");

    // Test 1
    load(8'hAA);
    send(8'h00, 1'b1);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd3);
    send(8'h00, 1'b0);
    exp_q = {8'hAA, 8'h55, 8'hAB, 8'h57};
    check_rx("t1_data");

    // Test 2: sof resync
    send(8'hE2, 1'b1);
    check("t2_cnt_a", 32'(frame_cnt), 32'd1);
    send(8'h00, 1'b0);
    check("t2_cnt_b", 32'(frame_cnt), 32'd2);
    send(8'hE2, 1'b1);
    check("t2_cnt_c", 32'(frame_cnt), 32'd1);
    exp_q = {8'h48, 8'h55, 8'h48};
    check_rx("t2_data");

    // Test 3: backpressure with a full buffer
    out_ready = 1'b0;
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h30;
    step(); step();
    check("t3_held_ready", 32'(in_ready),  32'd0);
    check("t3_held_cnt",   32'(frame_cnt), 32'd2);
    check("t3_head",       32'(out_data),  32'hBA);
    check("t3_out_valid",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send(8'h30, 1'b0);
    check("t3_cnt_end", 32'(frame_cnt), 32'd3);
    exp_q = {8'hBA, 8'h75, 8'h9B};
    check_rx("t3_data");

    // Test 6: asynchronous reset with two bytes buffered
    out_ready = 1'b0;
    send(8'h00, 1'b1);
    send(8'h00, 1'b0);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 clear = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_keyed",     32'(keyed),     32'd0);
    check("t6_in_ready",  32'(in_ready),  32'd0);
    check("t6_out_data",  32'(out_data),  32'h00);
    step();
    clear = 1'b1;
    step();
    check("t6_after_valid", 32'(out_valid), 32'd0);
    check("t6_rx_empty",    32'(rx.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
